// File: rtl/pong_pkg.sv
// Shared types and constants for the pong match controller.
// State encoding, 7-segment table, BCD helpers, playfield sizes.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SERVE,
    PLAY,
    POINT,
    GAMEOVER
  } state_t;

  localparam int PADDLE_W  = 8;
  localparam int PADDLE_H  = 64;
  localparam int BALL_SIZE = 8;

  // active-low {g..a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_LUT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  function automatic logic [7:0] to_bcd(input int n);
    int v;
    v = (n > 99) ? 99 : n;
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Tens saturate at 9, so 99 stays 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] != 4'd9)
      return {v[7:4], v[3:0] + 4'd1};
    if (v[7:4] != 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return v;
  endfunction

endpackage

// File: rtl/pong_score_ctrl_seg7_mux.sv
// Multiplexed 4-digit score display: refresh counter,
// digit select and BCD-to-segment decode, registered outputs.
module seg7_mux
  import pong_pkg::*;
#(
  parameter int REFRESH_BITS = 17
) (
  input  logic       clk50M,
  input  logic       reset_n,
  input  logic [7:0] score_p1,
  input  logic [7:0] score_p2,
  output logic [6:0] seg,
  output logic [3:0] an
);

  logic [REFRESH_BITS-1:0] cnt;
  logic [1:0]              sel;
  logic [3:0]              digit;
  logic                    blank;
  logic [6:0]              seg_n;
  logic [3:0]              an_n;

  assign sel = cnt[REFRESH_BITS-1 -: 2];

  always_comb begin
    digit = score_p2[3:0];
    blank = 1'b0;
    unique case (sel)
      2'd3: begin
        digit = score_p1[7:4];
        blank = (score_p1[7:4] == 4'd0);
      end
      2'd2: digit = score_p1[3:0];
      2'd1: begin
        digit = score_p2[7:4];
        blank = (score_p2[7:4] == 4'd0);
      end
      2'd0: digit = score_p2[3:0];
    endcase
    if (blank || digit > 4'd9)
      seg_n = SEG_BLANK;
    else
      seg_n = SEG_LUT[digit];
    an_n = ~(4'b0001 << sel);
  end

  always_ff @(posedge clk50M) begin
    if (!reset_n) begin
      cnt <= '0;
      seg <= SEG_BLANK;
      an  <= 4'hF;
    end else begin
      cnt <= cnt + 1'b1;
      seg <= seg_n;
      an  <= an_n;
    end
  end

endmodule

// File: rtl/pong_score_ctrl.sv
// Pong match controller: serve/play/point/game-over sequencing.
// Optional tone output when PONG_SCORE_BEEP_EN is defined.
module pong_score_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 11,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
`ifdef PONG_SCORE_BEEP_EN
  parameter int BEEP_HALF    = 56818,
  parameter int BEEP_FRAMES  = 6,
`endif
  parameter int REFRESH_BITS = 17
) (
  input  logic       clk50M,
  input  logic       reset_n,
  input  logic       endofframe,
  input  logic       start,
  input  logic       miss_p1,
  input  logic       miss_p2,
  input  logic       collided,
  output logic       ball_hold,
  output logic [7:0] score_p1,
  output logic [7:0] score_p2,
  output logic       game_over,
  output logic       winner,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       beep
);

  localparam logic [7:0] WIN_BCD = to_bcd(WIN_SCORE);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);

  state_t     state, state_n;
  logic [1:0] start_sync, eof_sync;
  logic       start_prev, eof_prev;
  logic       start_edge, frame_tick;
  logic [7:0] fcnt;
  logic       clr_scores, inc_p1, inc_p2;
  logic       fcnt_clr, fcnt_inc, latch_win;
  logic       win_p1, win_p2;

  // Synchronisers keep sampling through reset so a held
  // button is already seen high when reset releases.
  always_ff @(posedge clk50M) begin
    start_sync <= {start_sync[0], start};
    eof_sync   <= {eof_sync[0], endofframe};
  end

  assign start_edge = start_sync[1] & ~start_prev;
  assign frame_tick = eof_sync[1] & ~eof_prev;
  assign win_p1     = (score_p1 == WIN_BCD);
  assign win_p2     = (score_p2 == WIN_BCD);

  always_ff @(posedge clk50M) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n    = state;
    clr_scores = 1'b0;
    inc_p1     = 1'b0;
    inc_p2     = 1'b0;
    fcnt_clr   = 1'b0;
    fcnt_inc   = 1'b0;
    latch_win  = 1'b0;
    unique case (state)
      IDLE, GAMEOVER: begin
        if (start_edge) begin
          state_n    = SERVE;
          clr_scores = 1'b1;
          fcnt_clr   = 1'b1;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          if (fcnt == SERVE_LAST) begin
            state_n  = PLAY;
            fcnt_clr = 1'b1;
          end else begin
            fcnt_inc = 1'b1;
          end
        end
      end
      PLAY: begin
        if (frame_tick && (miss_p1 || miss_p2)) begin
          state_n  = POINT;
          fcnt_clr = 1'b1;
          inc_p2   = miss_p1 & ~miss_p2;
          inc_p1   = miss_p2 & ~miss_p1;
        end
      end
      POINT: begin
        if (frame_tick) begin
          if (fcnt == POINT_LAST) begin
            fcnt_clr = 1'b1;
            if (win_p1 || win_p2) begin
              state_n   = GAMEOVER;
              latch_win = 1'b1;
            end else begin
              state_n = SERVE;
            end
          end else begin
            fcnt_inc = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Edge registers reset high: an edge needs a low seen after reset.
  always_ff @(posedge clk50M) begin
    if (!reset_n) begin
      start_prev <= 1'b1;
      eof_prev   <= 1'b1;
      fcnt       <= '0;
      score_p1   <= '0;
      score_p2   <= '0;
      winner     <= 1'b0;
    end else begin
      start_prev <= start_sync[1];
      eof_prev   <= eof_sync[1];
      if (fcnt_clr)      fcnt <= '0;
      else if (fcnt_inc) fcnt <= fcnt + 8'd1;
      if (clr_scores) begin
        score_p1 <= '0;
        score_p2 <= '0;
      end else begin
        if (inc_p1) score_p1 <= bcd_inc(score_p1);
        if (inc_p2) score_p2 <= bcd_inc(score_p2);
      end
      if (latch_win) winner <= win_p2;
    end
  end

  assign ball_hold = (state != PLAY);
  assign game_over = (state == GAMEOVER);

  seg7_mux #(
    .REFRESH_BITS(REFRESH_BITS)
  ) u_seg7 (
    .clk50M  (clk50M),
    .reset_n (reset_n),
    .score_p1(score_p1),
    .score_p2(score_p2),
    .seg     (seg),
    .an      (an)
  );

`ifdef PONG_SCORE_BEEP_EN
  localparam int BW = $clog2(2 * BEEP_HALF);
  localparam int FW = $clog2(BEEP_FRAMES + 1);
  localparam logic [BW-1:0] HI_LAST = BW'(BEEP_HALF - 1);
  localparam logic [BW-1:0] LO_LAST = BW'(2 * BEEP_HALF - 1);
  localparam logic [FW-1:0] BF_LAST = FW'(BEEP_FRAMES - 1);

  logic [BW-1:0] bcnt;
  logic [FW-1:0] bfr;
  logic          bact, blow, beep_q;
  logic          hit, pt;

  assign hit = (state == PLAY) && frame_tick && collided;
  assign pt  = inc_p1 || inc_p2;

  // Point tone uses the doubled half-period (lower pitch).
  always_ff @(posedge clk50M) begin
    if (!reset_n) begin
      bcnt   <= '0;
      bfr    <= '0;
      bact   <= 1'b0;
      blow   <= 1'b0;
      beep_q <= 1'b0;
    end else if (hit || pt) begin
      bcnt   <= '0;
      bfr    <= '0;
      bact   <= 1'b1;
      blow   <= pt;
      beep_q <= 1'b0;
    end else if (bact) begin
      if (frame_tick && bfr == BF_LAST) begin
        bact   <= 1'b0;
        beep_q <= 1'b0;
      end else begin
        if (frame_tick) bfr <= bfr + 1'b1;
        if (bcnt == (blow ? LO_LAST : HI_LAST)) begin
          bcnt   <= '0;
          beep_q <= ~beep_q;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end
    end
  end

  assign beep = beep_q;
`else
  logic unused_collided;
  assign unused_collided = collided;
  assign beep = 1'b0;
`endif

endmodule

// File: tb/tb_pong_score_ctrl.sv
// Directed bench for pong_score_ctrl with immediate assertions.
// Instance a: WIN_SCORE=3; instance b: WIN_SCORE=99 for BCD/display.
module tb_pong_score_ctrl;
  import pong_pkg::*;

  localparam int BH = 3;

  logic clk = 1'b0;
  logic reset_n, endofframe, start, miss_p1, miss_p2, collided;
  logic start_b, miss_p1_b, miss_p2_b;

  logic       ball_hold_a, game_over_a, winner_a, beep_a;
  logic [7:0] score_p1_a, score_p2_a;
  logic [6:0] seg_a;
  logic [3:0] an_a;
  logic       ball_hold_b, game_over_b, winner_b, beep_b;
  logic [7:0] score_p1_b, score_p2_b;
  logic [6:0] seg_b;
  logic [3:0] an_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pong_score_ctrl #(
    .WIN_SCORE(3), .SERVE_FRAMES(2), .POINT_FRAMES(2),
`ifdef PONG_SCORE_BEEP_EN
    .BEEP_HALF(BH), .BEEP_FRAMES(2),
`endif
    .REFRESH_BITS(4)
  ) dut_a (
    .clk50M(clk), .reset_n(reset_n),
    .endofframe(endofframe), .start(start),
    .miss_p1(miss_p1), .miss_p2(miss_p2),
    .collided(collided), .ball_hold(ball_hold_a),
    .score_p1(score_p1_a), .score_p2(score_p2_a),
    .game_over(game_over_a), .winner(winner_a),
    .seg(seg_a), .an(an_a), .beep(beep_a)
  );

  pong_score_ctrl #(
    .WIN_SCORE(99), .SERVE_FRAMES(2), .POINT_FRAMES(2),
`ifdef PONG_SCORE_BEEP_EN
    .BEEP_HALF(BH), .BEEP_FRAMES(2),
`endif
    .REFRESH_BITS(4)
  ) dut_b (
    .clk50M(clk), .reset_n(reset_n),
    .endofframe(endofframe), .start(start_b),
    .miss_p1(miss_p1_b), .miss_p2(miss_p2_b),
    .collided(collided), .ball_hold(ball_hold_b),
    .score_p1(score_p1_b), .score_p2(score_p2_b),
    .game_over(game_over_b), .winner(winner_b),
    .seg(seg_b), .an(an_b), .beep(beep_b)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame();
    endofframe = 1'b1;
    step(4);
    endofframe = 1'b0;
    step(4);
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    logic [3:0] seen;
    logic       bad, ok;
    logic [6:0] s0, s1, s2, s3;
    int         n, hi, lo;

    reset_n = 1'b0; endofframe = 1'b0; start = 1'b1;
    miss_p1 = 1'b0; miss_p2 = 1'b0; collided = 1'b0;
    start_b = 1'b0; miss_p1_b = 1'b0; miss_p2_b = 1'b0;
    step(2);
    chk("rst_hold", 8'(ball_hold_a), 8'h01);
    chk("rst_p1", score_p1_a, 8'h00);
    chk("rst_p2", score_p2_a, 8'h00);
    chk("rst_go", {6'd0, game_over_a, winner_a}, 8'h00);
    chk("rst_an", 8'(an_a), 8'h0F);
    chk("rst_seg", 8'(seg_a), 8'h7F);
    chk("rst_beep", 8'(beep_a), 8'h00);
    reset_n = 1'b1;

    // start held through reset must not fire
    step(4);
    chk("held_start", 8'(dut_a.state), 8'(IDLE));
    start = 1'b0; step(4);
    start = 1'b1; step(4);
    start = 1'b0; step(4);
    chk("start_serve", 8'(dut_a.state), 8'(SERVE));
    frame();
    chk("serve_f1", 8'(ball_hold_a), 8'h01);
    frame();
    chk("serve_f2", 8'(ball_hold_a), 8'h00);
    chk("serve_sc", score_p1_a, 8'h00);

    // P2 misses -> P1 scores
    miss_p2 = 1'b1; frame(); miss_p2 = 1'b0;
    chk("pt_p1", score_p1_a, 8'h01);
    chk("pt_p2", score_p2_a, 8'h00);
    chk("pt_st", 8'(dut_a.state), 8'(POINT));
    frames(2);
    chk("pt_serve", 8'(dut_a.state), 8'(SERVE));
    frame();
    chk("pt_hold3", 8'(ball_hold_a), 8'h01);
    frame();
    chk("pt_play", 8'(ball_hold_a), 8'h00);

    // both miss together -> no score
    miss_p1 = 1'b1; miss_p2 = 1'b1; frame();
    miss_p1 = 1'b0; miss_p2 = 1'b0;
    chk("both_st", 8'(dut_a.state), 8'(POINT));
    chk("both_sc", {score_p1_a[3:0], score_p2_a[3:0]}, 8'h10);
    frames(4);
    chk("both_play", 8'(ball_hold_a), 8'h00);

    // three P2 points win at WIN_SCORE=3
    repeat (3) begin
      miss_p1 = 1'b1; frame(); miss_p1 = 1'b0;
      frames(4);
    end
    chk("win_p2", score_p2_a, 8'h03);
    chk("win_go", 8'(game_over_a), 8'h01);
    chk("win_who", 8'(winner_a), 8'h01);
    chk("win_hold", 8'(ball_hold_a), 8'h01);
    miss_p2 = 1'b1; frame(); miss_p2 = 1'b0;
    chk("go_ignore", score_p1_a, 8'h01);
    chk("go_stay", 8'(game_over_a), 8'h01);
    start = 1'b1; step(4);
    start = 1'b0; step(4);
    chk("re_p1", score_p1_a, 8'h00);
    chk("re_p2", score_p2_a, 8'h00);
    chk("re_st", 8'(dut_a.state), 8'(SERVE));
    chk("re_go", 8'(game_over_a), 8'h00);

    // BCD carry on instance b
    start_b = 1'b1; step(4);
    start_b = 1'b0; step(4);
    frames(2);
    chk("b_play", 8'(ball_hold_b), 8'h00);
    repeat (9) begin
      miss_p2_b = 1'b1; frame(); miss_p2_b = 1'b0;
      frames(4);
    end
    chk("bcd_9", score_p1_b, 8'h09);
    miss_p2_b = 1'b1; frame(); miss_p2_b = 1'b0;
    chk("bcd_10", score_p1_b, 8'h10);
    chk("bcd_go", 8'(game_over_b), 8'h00);
    frames(4);

    seen = '0; bad = 1'b0;
    s0 = '0; s1 = '0; s2 = '0; s3 = '0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      case (an_b)
        4'b1110: begin seen[0] = 1'b1; s0 = seg_b; end
        4'b1101: begin seen[1] = 1'b1; s1 = seg_b; end
        4'b1011: begin seen[2] = 1'b1; s2 = seg_b; end
        4'b0111: begin seen[3] = 1'b1; s3 = seg_b; end
        default: bad = 1'b1;
      endcase
    end
    chk("scan_an", {3'd0, bad, seen}, 8'h0F);
    chk("seg_d3", 8'(s3), 8'h79);
    chk("seg_d2", 8'(s2), 8'h40);
    chk("seg_d1", 8'(s1), 8'h7F);
    chk("seg_d0", 8'(s0), 8'h40);

`ifdef PONG_SCORE_BEEP_EN
    chk("bp_play", 8'(ball_hold_a), 8'h00);
    collided = 1'b1; frame(); collided = 1'b0;
    n = 0;
    while (beep_a !== 1'b0 && n < 200) begin step(1); n++; end
    while (beep_a !== 1'b1 && n < 200) begin step(1); n++; end
    hi = 0;
    while (beep_a === 1'b1 && hi < 200) begin step(1); hi++; end
    lo = 0;
    while (beep_a === 1'b0 && lo < 200) begin step(1); lo++; end
    chk("beep_hi", 8'(hi), 8'(BH));
    chk("beep_lo", 8'(lo), 8'(BH));
    frames(2);
    ok = 1'b1;
    repeat (20) begin
      step(1);
      if (beep_a !== 1'b0) ok = 1'b0;
    end
    chk("beep_off", 8'(ok), 8'h01);
`endif

    // reset during POINT
    miss_p2 = 1'b1; frame(); miss_p2 = 1'b0;
    chk("mid_st", 8'(dut_a.state), 8'(POINT));
    chk("mid_p1", score_p1_a, 8'h01);
    reset_n = 1'b0;
    step(1);
    chk("mrst_st", 8'(dut_a.state), 8'(IDLE));
    chk("mrst_p1", score_p1_a, 8'h00);
    chk("mrst_p2", score_p2_a, 8'h00);
    chk("mrst_hold", 8'(ball_hold_a), 8'h01);
    chk("mrst_b", score_p1_b, 8'h00);
    reset_n = 1'b1;
    step(2);
    chk("end_beep", 8'(beep_a), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
